// File: rtl/neopx_stream_serializer.sv
// neopx_stream_serializer: AXI-Stream fed WS2812/SK6812 one-wire serializer with
// a one-entry holding buffer, gapless pixel chaining and automatic end-of-frame latch.
module neopx_stream_serializer #(
    parameter int BITS_PER_PIXEL = 24,
    parameter int T0H            = 28,
    parameter int T0L            = 61,
    parameter int T1H            = 57,
    parameter int T1L            = 32,
    parameter int RESET_COUNT    = 6600,
    parameter int OUT_INVERT     = 0,
    parameter int CNT_W          = 16
) (
    input  logic        axis_aclk,
    input  logic        axis_aresetn,
    input  logic [31:0] s_axis_data,
    input  logic        s_axis_valid,
    input  logic        s_axis_last,
    output logic        s_axis_ready,
    output logic        o_serial,
    output logic        o_busy,
    output logic        o_underrun,
    output logic        o_frame_done
);
    typedef enum logic [1:0] {IDLE, HIGH, LOW, LATCH} state_e;

    localparam int IW = $clog2(BITS_PER_PIXEL);
    localparam logic [IW-1:0] LAST_BIT = IW'(BITS_PER_PIXEL - 1);
    localparam logic [CNT_W-1:0] C0H = CNT_W'(T0H - 1);
    localparam logic [CNT_W-1:0] C0L = CNT_W'(T0L - 1);
    localparam logic [CNT_W-1:0] C1H = CNT_W'(T1H - 1);
    localparam logic [CNT_W-1:0] C1L = CNT_W'(T1L - 1);
    localparam logic [CNT_W-1:0] CRST = CNT_W'(RESET_COUNT - 1);
    localparam logic INV = OUT_INVERT != 0;

    if (BITS_PER_PIXEL < 8 || BITS_PER_PIXEL > 32 || T0H < 1 || T0L < 1 || T1H < 1 ||
        T1L < 1 || RESET_COUNT < 1 || T0H > 2**CNT_W || T0L > 2**CNT_W ||
        T1H > 2**CNT_W || T1L > 2**CNT_W || RESET_COUNT > 2**CNT_W) begin : g_param_err
        $error("neopx_stream_serializer: illegal parameter value");
    end

    state_e            state_q, state_d;
    logic [31:0]       sh_q, sh_d, buf_q, buf_d;
    logic              bufv_q, bufv_d, bufl_q, bufl_d, cur_last_q, cur_last_d;
    logic [IW-1:0]     bit_q, bit_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              alive_q, ser_q, ur_q, fd_q, ser_d, ur_d, fd_d;
    logic              accept, take;

    assign s_axis_ready = alive_q && !bufv_q;
    assign accept       = s_axis_valid && s_axis_ready;
    assign o_serial     = ser_q;
    assign o_busy       = state_q != IDLE || bufv_q;
    assign o_underrun   = ur_q;
    assign o_frame_done = fd_q;

    always_comb begin
        state_d    = state_q;
        sh_d       = sh_q;
        bit_d      = bit_q;
        cnt_d      = cnt_q;
        cur_last_d = cur_last_q;
        take       = 1'b0;
        case (state_q)
            IDLE:  take = bufv_q;
            HIGH: begin
                state_d = cnt_q == '0 ? LOW : HIGH;
                cnt_d   = cnt_q == '0 ? (sh_q[31] ? C1L : C0L) : cnt_q - 1'b1;
            end
            LOW: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (bit_q != LAST_BIT) begin
                    state_d = HIGH;
                    sh_d    = sh_q << 1;
                    bit_d   = bit_q + 1'b1;
                    cnt_d   = sh_q[30] ? C1H : C0H;
                end else if (cur_last_q) begin
                    state_d = LATCH;
                    cnt_d   = CRST;
                end else begin
                    take    = bufv_q;
                    state_d = IDLE;
                end
            end
            default: begin
                cnt_d   = cnt_q == '0 ? cnt_q : cnt_q - 1'b1;
                take    = cnt_q == '0 && bufv_q;
                state_d = cnt_q == '0 ? IDLE : LATCH;
            end
        endcase
        // A waiting pixel starts its first high right away, with no gap cycle
        if (take) begin
            state_d    = HIGH;
            sh_d       = buf_q;
            bit_d      = '0;
            cur_last_d = bufl_q;
            cnt_d      = buf_q[31] ? C1H : C0H;
        end
        bufv_d = accept ? 1'b1 : (take ? 1'b0 : bufv_q);
        buf_d  = accept ? s_axis_data : buf_q;
        bufl_d = accept ? s_axis_last : bufl_q;
        // Pulses are predicted one cycle ahead so they coincide with the final cycle
        ur_d   = state_d == LOW && cnt_d == '0 && bit_d == LAST_BIT && !cur_last_d && !bufv_d;
        fd_d   = state_d == LATCH && cnt_d == '0;
        ser_d  = (state_d == HIGH) ^ INV;
    end

    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            state_q    <= IDLE;
            sh_q       <= '0;
            buf_q      <= '0;
            bufv_q     <= 1'b0;
            bufl_q     <= 1'b0;
            cur_last_q <= 1'b0;
            bit_q      <= '0;
            cnt_q      <= '0;
            alive_q    <= 1'b0;
            ser_q      <= INV;
            ur_q       <= 1'b0;
            fd_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            sh_q       <= sh_d;
            buf_q      <= buf_d;
            bufv_q     <= bufv_d;
            bufl_q     <= bufl_d;
            cur_last_q <= cur_last_d;
            bit_q      <= bit_d;
            cnt_q      <= cnt_d;
            alive_q    <= 1'b1;
            ser_q      <= ser_d;
            ur_q       <= ur_d;
            fd_q       <= fd_d;
        end
    end
endmodule

// File: tb/tb_neopx_stream_serializer.sv
// tb_neopx_stream_serializer: directed checks of waveform timing, chaining, underrun,
// latch, reset abort and an inverted RGBW instance with short timings.
module tb_neopx_stream_serializer;
    localparam int TH0 [2] = '{28, 2};
    localparam int TL0 [2] = '{61, 3};
    localparam int TH1 [2] = '{57, 4};
    localparam int TL1 [2] = '{32, 2};
    localparam int RST [2] = '{6600, 10};
    localparam logic INV [2] = '{1'b0, 1'b1};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] dat [2];
    logic        vld [2];
    logic        lst [2];
    logic        rdy [2];
    logic        ser [2];
    logic        bsy [2];
    logic        ur  [2];
    logic        fd  [2];
    int          tests = 0;
    int          fails = 0;
    int          fdc [2] = '{0, 0};
    int          fd_before;

    always #5 clk = ~clk;

    neopx_stream_serializer u_dut0 (
        .axis_aclk(clk), .axis_aresetn(rst_n), .s_axis_data(dat[0]), .s_axis_valid(vld[0]),
        .s_axis_last(lst[0]), .s_axis_ready(rdy[0]), .o_serial(ser[0]), .o_busy(bsy[0]),
        .o_underrun(ur[0]), .o_frame_done(fd[0]));

    neopx_stream_serializer #(
        .BITS_PER_PIXEL(32), .T0H(2), .T0L(3), .T1H(4), .T1L(2), .RESET_COUNT(10),
        .OUT_INVERT(1), .CNT_W(8)
    ) u_dut1 (
        .axis_aclk(clk), .axis_aresetn(rst_n), .s_axis_data(dat[1]), .s_axis_valid(vld[1]),
        .s_axis_last(lst[1]), .s_axis_ready(rdy[1]), .o_serial(ser[1]), .o_busy(bsy[1]),
        .o_underrun(ur[1]), .o_frame_done(fd[1]));

    always @(negedge clk) begin
        if (fd[0]) fdc[0]++;
        if (fd[1]) fdc[1]++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic send(input int d, input logic [31:0] w, input logic l, input string tag);
        int n = 0;
        @(negedge clk);
        vld[d] = 1'b1;
        dat[d] = w;
        lst[d] = l;
        while (!rdy[d] && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(rdy[d]), 1);
        @(posedge clk);
        #1 vld[d] = 1'b0;
    endtask

    // Checks every cycle of one pixel from its first high cycle on
    task automatic check_px(input int d, input logic [31:0] w, input int nb, input logic ur_exp,
                            input string tag);
        int bad = 0;
        logic [31:0] s = w;
        logic rd0 = 1'b0;
        logic ur_end = 1'b0;
        for (int i = 0; i < nb; i++) begin
            int h = s[31] ? TH1[d] : TH0[d];
            int l = s[31] ? TL1[d] : TL0[d];
            for (int c = 0; c < h + l; c++) begin
                @(negedge clk);
                if (i == 0 && c == 0) rd0 = rdy[d];
                if (ser[d] !== ((c < h) ^ INV[d])) bad++;
                if (fd[d] !== 1'b0 || bsy[d] !== 1'b1) bad++;
                if (i == nb - 1 && c == h + l - 1) ur_end = ur[d];
                else if (ur[d] !== 1'b0) bad++;
            end
            s = s << 1;
        end
        chk({tag, "_wave"}, bad, 0);
        chk({tag, "_ready"}, 32'(rd0), 1);
        chk({tag, "_underrun"}, 32'(ur_end), 32'(ur_exp));
    endtask

    task automatic check_latch(input int d, input string tag);
        int bad = 0;
        for (int i = 0; i < RST[d]; i++) begin
            @(negedge clk);
            if (ser[d] !== INV[d] || bsy[d] !== 1'b1 || ur[d] !== 1'b0) bad++;
            if (fd[d] !== (i == RST[d] - 1)) bad++;
        end
        chk({tag, "_latch"}, bad, 0);
    endtask

    task automatic check_quiet(input int d, input int n, input string tag);
        int bad = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (ser[d] !== INV[d] || bsy[d] !== 1'b0 || ur[d] !== 1'b0 || fd[d] !== 1'b0) bad++;
        end
        chk({tag, "_quiet"}, bad, 0);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            vld[d] = 1'b0;
            lst[d] = 1'b0;
            dat[d] = '0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_serial", 32'(ser[d]), 32'(INV[d]));
            chk("rst_ready", 32'(rdy[d]), 0);
            chk("rst_busy", 32'(bsy[d]), 0);
            chk("rst_pulses", {30'd0, ur[d], fd[d]}, 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_ready0", 32'(rdy[0]), 1);
        chk("rel_ready1", 32'(rdy[1]), 1);

        // RGBW inverted instance, both end bits set
        send(1, 32'h8000_0001, 1'b1, "rgbw_acc");
        @(negedge clk);
        chk("rgbw_pre", 32'(ser[1]), 1);
        check_px(1, 32'h8000_0001, 32, 1'b0, "rgbw");
        check_latch(1, "rgbw");
        check_quiet(1, 3, "rgbw_after");
        chk("rgbw_fd_count", fdc[1], 1);

        // Single pixel with default timing
        send(0, 32'hFF00_0000, 1'b1, "single_acc");
        @(negedge clk);
        chk("single_pre", 32'(ser[0]), 0);
        check_px(0, 32'hFF00_0000, 24, 1'b0, "single");
        check_latch(0, "single");
        check_quiet(0, 2, "single_after");
        chk("single_fd_count", fdc[0], 1);

        // Three chained pixels, valid held while the buffer is full
        fd_before = fdc[0];
        send(0, 32'hAA55_0012, 1'b0, "b2b_acc0");
        fork
            begin
                send(0, 32'h00FF_0034, 1'b0, "b2b_acc1");
                send(0, 32'h0000_FF56, 1'b1, "b2b_acc2");
            end
            begin
                @(negedge clk);
                chk("b2b_pre", 32'(ser[0]), 0);
                check_px(0, 32'hAA55_0012, 24, 1'b0, "b2b_p0");
                check_px(0, 32'h00FF_0034, 24, 1'b0, "b2b_p1");
                check_px(0, 32'h0000_FF56, 24, 1'b0, "b2b_p2");
                check_latch(0, "b2b");
            end
        join
        check_quiet(0, 2, "b2b_after");
        chk("b2b_fd_count", fdc[0] - fd_before, 1);

        // Starved stream mid-frame, then a normal frame
        fd_before = fdc[0];
        send(0, 32'hC300_0000, 1'b0, "ur_acc");
        @(negedge clk);
        check_px(0, 32'hC300_0000, 24, 1'b1, "ur");
        check_quiet(0, 50, "ur_after");
        chk("ur_fd_count", fdc[0] - fd_before, 0);
        send(0, 32'h0100_0000, 1'b1, "ur_next_acc");
        @(negedge clk);
        check_px(0, 32'h0100_0000, 24, 1'b0, "ur_next");
        check_latch(0, "ur_next");
        check_quiet(0, 2, "ur_next_after");

        // Reset around bit 10 with a second pixel buffered
        fd_before = fdc[0];
        send(0, 32'hA5A5_A500, 1'b1, "mid_acc0");
        send(0, 32'h1234_5600, 1'b1, "mid_acc1");
        repeat (10 * 89) @(negedge clk);
        chk("mid_busy", 32'(bsy[0]), 1);
        chk("mid_ready_full", 32'(rdy[0]), 0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_serial", 32'(ser[0]), 0);
        chk("mid_rst_ready", 32'(rdy[0]), 0);
        chk("mid_rst_busy", 32'(bsy[0]), 0);
        repeat (3) @(negedge clk);
        chk("mid_rst_hold_ready", 32'(rdy[0]), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rel_ready", 32'(rdy[0]), 1);
        check_quiet(0, 200, "mid_after");
        chk("mid_fd_count", fdc[0] - fd_before, 0);

        // New frame; next frame's pixel is offered during its latch
        send(0, 32'h0F0F_0F00, 1'b1, "post_acc");
        @(negedge clk);
        check_px(0, 32'h0F0F_0F00, 24, 1'b0, "post");
        fork
            check_latch(0, "post");
            begin
                repeat (100) @(negedge clk);
                send(0, 32'h3C00_0000, 1'b1, "latch_acc");
                @(negedge clk);
                chk("latch_acc_serial_low", 32'(ser[0]), 0);
            end
        join
        check_px(0, 32'h3C00_0000, 24, 1'b0, "latch_px");
        check_latch(0, "latch_px");
        check_quiet(0, 2, "latch_px_after");
        chk("final_fd_count", fdc[0] - fd_before, 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
